// File: rtl/console_text_buffer_pkg.sv
// console_text_buffer_pkg: shared geometry, ASCII codes, cell layout
// and writer FSM encodings for the text console.
package console_text_buffer_pkg;

    localparam int DEF_COLS = 40;
    localparam int DEF_ROWS = 30;
    localparam int DEF_TILE = 16;

    localparam logic [6:0] LF    = 7'h0A;
    localparam logic [6:0] CR    = 7'h0D;
    localparam logic [6:0] BS    = 7'h08;
    localparam logic [6:0] SPACE = 7'h20;
    localparam logic [6:0] TILDE = 7'h7E;

    localparam int CELL_W = 31;

    localparam int BLINK_FRAMES = 30;

    typedef enum logic [1:0] {
        CLEAR_ALL  = 2'd0,
        IDLE       = 2'd1,
        CLEAR_LINE = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [6:0]  ch;
        logic [11:0] fg;
        logic [11:0] bg;
    } cell_t;

    function automatic logic is_printable(logic [6:0] c);
        return (c >= SPACE) && (c <= TILDE);
    endfunction

endpackage

// File: rtl/console_text_buffer_text_ram.sv
// text_ram: simple dual-port cell memory, one write port and one
// registered read port; a same-address read returns the old word.
module text_ram
    import console_text_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_COLS * DEF_ROWS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CELL_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CELL_W-1:0] rdata
);

    logic [CELL_W-1:0] mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // registered read port
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/console_text_buffer.sv
// console_text_buffer: byte-stream text writer with scroll and clear,
// plus a one-cycle pixel-to-cell lookup. Option: CONSOLE_CURSOR_BLINK_EN.
module console_text_buffer
    import console_text_buffer_pkg::*;
#(
    parameter int          COLS   = DEF_COLS,
    parameter int          ROWS   = DEF_ROWS,
    parameter int          TILE   = DEF_TILE,
    parameter logic [11:0] DEF_FG = 12'hFFF,
    parameter logic [11:0] DEF_BG = 12'h000
) (
    input  logic                      pix_clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [6:0]                in_char,
    input  logic [11:0]               in_fg,
    input  logic [11:0]               in_bg,
    input  logic                      clr,
    input  logic                      rd_en,
    input  logic [11:0]               rd_x,
    input  logic [11:0]               rd_y,
    input  logic                      new_frame,
    output logic [6:0]                char,
    output logic [11:0]               char_color,
    output logic [11:0]               back_color,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic [$clog2(ROWS)-1:0]   cur_row
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int TB    = $clog2(TILE);

    localparam cell_t BLANK = '{ch: SPACE, fg: DEF_FG, bg: DEF_BG};

    buf_state_t    state;
    logic [AW-1:0] cnt;
    logic [RW-1:0] row_base;
    logic [RW-1:0] line_row;

    logic          accept;
    logic          is_print;
    logic          col_last;
    logic          adv;
    logic [RW-1:0] wr_phys;

    logic          we;
    logic [AW-1:0] waddr;
    cell_t         wdata;
    logic [AW-1:0] raddr;
    cell_t         rd_cell;

    logic [11:0]   tcol;
    logic [11:0]   trow;
    logic          rd_hit;
    logic [RW-1:0] rd_phys;

    logic          cur_hit;
    logic          hit_q;
    logic          swap_q;

    // logical row to physical row: one compare-subtract, no divider
    function automatic logic [RW-1:0] phys_row(
        logic [RW-1:0] r,
        logic [RW-1:0] base
    );
        logic [RW:0] s;
        s = {1'b0, r} + {1'b0, base};
        if (s >= (RW+1)'(ROWS)) begin
            s = s - (RW+1)'(ROWS);
        end
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(
        logic [RW-1:0] r,
        logic [CW-1:0] c
    );
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    assign in_ready = (state == IDLE) && !clr;
    assign accept   = in_valid && in_ready;
    assign is_print = is_printable(in_char);
    assign col_last = (cur_col == CW'(COLS - 1));
    assign adv      = accept &&
                      ((is_print && col_last) || (in_char == LF));
    assign wr_phys  = phys_row(cur_row, row_base);

    // write port: bulk clear, line clear or one printable byte
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = BLANK;
        unique case (state)
            CLEAR_ALL: begin
                we    = 1'b1;
                waddr = cnt;
            end
            CLEAR_LINE: begin
                we    = 1'b1;
                waddr = cell_addr(line_row, CW'(cnt));
            end
            IDLE: begin
                if (accept && is_print) begin
                    we    = 1'b1;
                    waddr = cell_addr(wr_phys, cur_col);
                    wdata = '{ch: in_char, fg: in_fg, bg: in_bg};
                end
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

    // writer FSM, cursor and scroll base
    always_ff @(posedge pix_clk) begin
        if (rst || clr) begin
            state    <= CLEAR_ALL;
            cnt      <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
            row_base <= '0;
            line_row <= '0;
        end else begin
            unique case (state)
                CLEAR_ALL: begin
                    if (cnt == AW'(CELLS - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLEAR_LINE: begin
                    if (cnt == AW'(COLS - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            is_print: begin
                                cur_col <= col_last ? '0
                                                    : cur_col + 1'b1;
                            end
                            (in_char == LF),
                            (in_char == CR): begin
                                cur_col <= '0;
                            end
                            (in_char == BS): begin
                                if (cur_col != '0) begin
                                    cur_col <= cur_col - 1'b1;
                                end
                            end
                            default: begin
                                cur_col <= cur_col;
                            end
                        endcase
                    end
                    if (adv) begin
                        if (cur_row != RW'(ROWS - 1)) begin
                            cur_row <= cur_row + 1'b1;
                        end else begin
                            row_base <= (row_base == RW'(ROWS - 1))
                                      ? '0 : row_base + 1'b1;
                            line_row <= row_base;
                            state    <= CLEAR_LINE;
                            cnt      <= '0;
                        end
                    end
                end
                default: begin
                    state <= CLEAR_ALL;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign tcol    = rd_x >> TB;
    assign trow    = rd_y >> TB;
    assign rd_hit  = rd_en &&
                     (tcol < 12'(COLS)) &&
                     (trow < 12'(ROWS));
    assign rd_phys = phys_row(trow[RW-1:0], row_base);
    assign raddr   = rd_hit ? cell_addr(rd_phys, tcol[CW-1:0]) : '0;

`ifdef CONSOLE_CURSOR_BLINK_EN
    logic [$clog2(BLINK_FRAMES)-1:0] frame_cnt;
    logic                            blink_phase;

    // frame counter toggles the cursor phase every BLINK_FRAMES frames
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (new_frame) begin
            if (frame_cnt == ($clog2(BLINK_FRAMES))'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign cur_hit = blink_phase &&
                     (tcol == 12'(cur_col)) &&
                     (trow == 12'(cur_row));
`else
    logic unused_new_frame;
    assign unused_new_frame = new_frame;
    assign cur_hit          = 1'b0;
`endif

    // qualifiers aligned with the registered RAM read
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            hit_q  <= 1'b0;
            swap_q <= 1'b0;
        end else begin
            hit_q  <= rd_hit;
            swap_q <= rd_hit && cur_hit;
        end
    end

    assign char       = hit_q ? rd_cell.ch : '0;
    assign char_color = !hit_q ? '0 : (swap_q ? rd_cell.bg : rd_cell.fg);
    assign back_color = !hit_q ? '0 : (swap_q ? rd_cell.fg : rd_cell.bg);

    text_ram #(
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_text_ram (
        .clk   (pix_clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rd_cell)
    );

endmodule

// File: tb/tb_console_text_buffer.sv
// tb_console_text_buffer: directed and random byte streams against a
// scrolling-screen model; checks cursor, busy time and cell lookups.
module tb_console_text_buffer;

    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int TILE = 16;

    logic        pix_clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_char;
    logic [11:0] in_fg;
    logic [11:0] in_bg;
    logic        clr;
    logic        rd_en;
    logic [11:0] rd_x;
    logic [11:0] rd_y;
    logic        new_frame;
    logic [6:0]  char;
    logic [11:0] char_color;
    logic [11:0] back_color;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;

    int checks = 0;
    int errors = 0;

    logic [6:0]  m_ch [ROWS][COLS];
    logic [11:0] m_fg [ROWS][COLS];
    logic [11:0] m_bg [ROWS][COLS];
    int          mcx;
    int          mcy;

    always #5 pix_clk = ~pix_clk;

    console_text_buffer dut (
        .pix_clk    (pix_clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .in_fg      (in_fg),
        .in_bg      (in_bg),
        .clr        (clr),
        .rd_en      (rd_en),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .new_frame  (new_frame),
        .char       (char),
        .char_color (char_color),
        .back_color (back_color),
        .cur_col    (cur_col),
        .cur_row    (cur_row)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                m_ch[r][c] = 7'h20;
                m_fg[r][c] = 12'hFFF;
                m_bg[r][c] = 12'h000;
            end
        end
        mcx = 0;
        mcy = 0;
    endtask

    // screen model: scrolling moves every line up and blanks the bottom
    task automatic model_advance(output bit sc);
        sc = 1'b0;
        if (mcy < ROWS - 1) begin
            mcy++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++) begin
                m_ch[r] = m_ch[r + 1];
                m_fg[r] = m_fg[r + 1];
                m_bg[r] = m_bg[r + 1];
            end
            for (int c = 0; c < COLS; c++) begin
                m_ch[ROWS-1][c] = 7'h20;
                m_fg[ROWS-1][c] = 12'hFFF;
                m_bg[ROWS-1][c] = 12'h000;
            end
            sc = 1'b1;
        end
    endtask

    task automatic model_byte(input logic [6:0] ch, input logic [11:0] fg,
                              input logic [11:0] bg, output bit sc);
        sc = 1'b0;
        if (ch >= 7'h20 && ch <= 7'h7E) begin
            m_ch[mcy][mcx] = ch;
            m_fg[mcy][mcx] = fg;
            m_bg[mcy][mcx] = bg;
            if (mcx == COLS - 1) begin
                mcx = 0;
                model_advance(sc);
            end else begin
                mcx++;
            end
        end else if (ch == 7'h0A) begin
            mcx = 0;
            model_advance(sc);
        end else if (ch == 7'h0D) begin
            mcx = 0;
        end else if (ch == 7'h08) begin
            if (mcx > 0) mcx--;
        end
    endtask

    // counts negedges with in_ready low, starting at the current one
    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 5000) begin
            n++;
            @(negedge pix_clk);
        end
    endtask

    // called at a negedge with in_ready high
    task automatic send(input logic [6:0] ch, input logic [11:0] fg,
                        input logic [11:0] bg);
        bit sc;
        int n;
        in_char  = ch;
        in_fg    = fg;
        in_bg    = bg;
        in_valid = 1'b1;
        @(posedge pix_clk);
        #1;
        in_valid = 1'b0;
        model_byte(ch, fg, bg, sc);
        @(negedge pix_clk);
        wait_ready(n);
        chk("busy_cycles", n, sc ? COLS : 0);
        chk("cur_col", cur_col, mcx);
        chk("cur_row", cur_row, mcy);
    endtask

    task automatic rd(input int x, input int y, input bit en);
        int          c;
        int          r;
        logic [6:0]  ec;
        logic [11:0] ef;
        logic [11:0] eb;
        c = x / TILE;
        r = y / TILE;
        rd_x  = 12'(x);
        rd_y  = 12'(y);
        rd_en = en;
        @(negedge pix_clk);
        if (en && c < COLS && r < ROWS) begin
            ec = m_ch[r][c];
            ef = m_fg[r][c];
            eb = m_bg[r][c];
        end else begin
            ec = '0;
            ef = '0;
            eb = '0;
        end
        chk("rd_char", char, ec);
        chk("rd_fg", char_color, ef);
        chk("rd_bg", back_color, eb);
        rd_en = 1'b0;
    endtask

    function automatic logic [6:0] rnd_byte();
        int k;
        k = $urandom_range(0, 19);
        if (k < 13) return 7'($urandom_range(32, 126));
        if (k < 16) return 7'h0A;
        if (k == 16) return 7'h0D;
        if (k == 17) return 7'h08;
        if (k == 18) return 7'h7F;
        return 7'($urandom_range(0, 31));
    endfunction

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = '0;
        in_fg     = '0;
        in_bg     = '0;
        clr       = 1'b0;
        rd_en     = 1'b0;
        rd_x      = '0;
        rd_y      = '0;
        new_frame = 1'b0;
        model_clear();

        repeat (2) @(posedge pix_clk);
        @(negedge pix_clk);
        chk("rst_char", char, 0);
        chk("rst_fg", char_color, 0);
        chk("rst_bg", back_color, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_col", cur_col, 0);
        chk("rst_row", cur_row, 0);

        rst = 1'b0;
        wait_ready(n);
        chk("init_clear_cycles", n, 1200);
        for (int i = 0; i < 8; i++) begin
            rd($urandom_range(0, 639), $urandom_range(0, 479), 1'b1);
        end
        rd(640, 0, 1'b1);
        rd(0, 480, 1'b1);
        rd(100, 100, 1'b0);

        send(7'h41, 12'hF00, 12'h00F);
        rd(5, 3, 1'b1);

        send(7'h0D, 12'h0, 12'h0);
        for (int i = 0; i < COLS; i++) begin
            send(7'h78, 12'($urandom), 12'($urandom));
        end
        rd(39 * TILE, 0, 1'b1);
        rd(0, TILE, 1'b1);

        send(7'h08, 12'h0, 12'h0);
        for (int i = 0; i < 5; i++) begin
            send(7'($urandom_range(33, 126)), 12'($urandom), 12'($urandom));
        end
        send(7'h08, 12'h0, 12'h0);
        send(7'h0D, 12'h0, 12'h0);
        send(7'h07, 12'h0, 12'h0);

        for (int i = 0; i < 29; i++) begin
            send(7'h0A, 12'h0, 12'h0);
        end
        for (int c = 0; c < 6; c++) begin
            rd(c * TILE + 7, 3, 1'b1);
        end

        send(7'h51, 12'h0F0, 12'h111);
        send(7'h52, 12'h0F0, 12'h111);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_char  = 7'h42;
        in_fg    = 12'hABC;
        in_bg    = 12'h123;
        #1;
        chk("clr_blocks_ready", in_ready, 0);
        @(posedge pix_clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        @(negedge pix_clk);
        wait_ready(n);
        chk("clr_cycles", n, 1200);
        chk("clr_col", cur_col, 0);
        chk("clr_row", cur_row, 0);
        rd(2 * TILE, 29 * TILE, 1'b1);
        rd(0, 0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            send(rnd_byte(), 12'($urandom), 12'($urandom));
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                rd(c * TILE + $urandom_range(0, TILE - 1),
                   r * TILE + $urandom_range(0, TILE - 1), 1'b1);
            end
        end
        for (int i = 0; i < 10; i++) begin
            rd($urandom_range(0, 800), $urandom_range(0, 600),
               1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
